fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter INSTR_W, default 32, meaning instruction word width.
REQ-003 SHALL have port Clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Branch_target  input  32  redirect address from the PC+immediate adder.
REQ-006 SHALL have port PC_sel  input  1  take Branch_target at next PC update.
REQ-007 SHALL have port Flush  input  1  discard held/pending instruction; redirect to Branch_target.
REQ-008 SHALL have port Mem_req  output  1  instruction-memory read request.
REQ-009 SHALL have port Mem_addr  output  32  read address, always equal to PC.
REQ-010 SHALL have port Mem_ready  input  1  Mem_rdata valid this cycle.
REQ-011 SHALL have port Mem_rdata  input  INSTR_W  fetched word.
REQ-012 SHALL have port Instr  output  INSTR_W  held instruction.
REQ-013 SHALL have port Instr_valid  output  1  Instr valid for decode.
REQ-014 SHALL have port Instr_ready  input  1  decode accepts Instr.
REQ-015 SHALL have port PC  output  32  address of Instr / current fetch.
REQ-016 SHALL have port PC_plus4  output  32  PC + 4, feeds adder In1.

Function
REQ-017 SHALL implement FSM IDLE, FETCH, VALID; IDLE->FETCH unconditionally; FETCH->VALID on Mem_ready; VALID->FETCH on accept (Instr_valid & Instr_ready).
REQ-018 Mem_req SHALL be 1 exactly in FETCH; Mem_addr SHALL stay stable while Mem_req=1 and Mem_ready=0.
REQ-019 On FETCH & Mem_ready, Instr SHALL capture Mem_rdata; Instr_valid SHALL be 1 from the next cycle.
REQ-020 Instr and Instr_valid SHALL hold unchanged in VALID until accept (no-drop, no-duplicate).
REQ-021 On accept, PC SHALL load Branch_target if PC_sel=1, else PC+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-022 PC_plus4 SHALL be combinational PC+4, 32-bit truncating.
REQ-023 Flush=1 in any state SHALL load PC=Branch_target, clear Instr_valid, go to FETCH next cycle; any Mem_ready in that cycle SHALL be ignored.
REQ-024 Flush SHALL take priority over accept and over Mem_ready in the same cycle.
REQ-025 PC_sel SHALL be sampled only on an accept cycle; elsewhere it SHALL be ignored.
REQ-026 Minimum latency: request cycle to Instr_valid = 1 cycle with Mem_ready same-cycle; back-to-back throughput one instruction per 2 cycles.

Reset
REQ-027 Reset=1 at a rising edge SHALL set state=IDLE, PC=RESET_PC, Instr=0, Instr_valid=0, Mem_req=0, overriding all other inputs.
REQ-028 Reset mid-FETCH SHALL drop Mem_req at the next edge; late Mem_ready SHALL be ignored.
REQ-029 First Mem_req SHALL assert in the second cycle after Reset deasserts (IDLE, then FETCH).

Configuration
REQ-030 With macro FETCH_MISALIGN_TRAP_EN defined, port Misalign (output, 1) SHALL set when a PC update would load an address with bits[1:0]!=0; PC SHALL not update, FSM SHALL hold in IDLE until Reset or Flush with aligned target.
REQ-031 Without FETCH_MISALIGN_TRAP_EN, Misalign SHALL not exist and PC SHALL load the target with bits[1:0] forced to 0.

Structure
REQ-032 State encoding (IDLE/FETCH/VALID), PC_STEP=4 and RESET_PC default SHALL live in shared package mips_pkg.
REQ-033 PC register and next-PC mux SHALL be one sub-module pc_next_reg; FSM and instruction register SHALL live in the top.

Verification
REQ-034 Reset, Mem_ready tied 1, Instr_ready tied 1 -> Mem_addr sequence 0x0,0x4,0x8; Instr_valid every other cycle.
REQ-035 Mem_ready held 0 for 5 cycles at PC=0x10 -> Mem_req=1 and Mem_addr=0x10 stable all 5 cycles; Instr captured on cycle 6.
REQ-036 Instr_valid=1, Instr_ready=0 for 3 cycles, Mem_rdata toggling -> Instr unchanged, PC unchanged.
REQ-037 Accept with PC_sel=1, Branch_target=0x40 at PC=0x8 -> next Mem_addr=0x40; Flush=1 and accept same cycle, target 0x80 -> PC=0x80, Instr_valid=0.
REQ-038 PC=0xFFFF_FFFC, accept, PC_sel=0 -> PC=0x0000_0000, PC_plus4=0x4.
REQ-039 Reset asserted in FETCH with Mem_ready=1 -> Instr_valid=0, PC=RESET_PC next cycle; with FETCH_MISALIGN_TRAP_EN, target 0x42 on accept -> Misalign=1, PC held.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage constants: FSM state encoding, PC step, reset PC and a
// word-alignment helper. Imported by fetch_pc_unit and pc_next_reg.
package mips_pkg;

    // FSM state encoding, kept as plain constants for older tool flows.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Clear the byte-offset bits so an address points at a whole word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_next_reg.sv
// Program counter register with its next-PC mux (sequential PC + 4 or an
// externally supplied target). The caller decides when the PC moves.
module pc_next_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic        take_target_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // 32-bit add truncates, so 32'hFFFF_FFFC steps to 32'h0000_0000.
    assign pc_plus4_o = pc_q + PC_STEP;
    assign pc_o       = pc_q;

    // Next-PC selection: hold unless told to load, then target or PC + 4.
    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = take_target_i ? target_i : pc_plus4_o;
        end
    end

    // PC register with synchronous reset to RESET_PC.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch unit: IDLE/FETCH/VALID handshake FSM, instruction holding
// register and PC control (PC register lives in pc_next_reg).
// Optional feature macro FETCH_MISALIGN_TRAP_EN: when defined, a PC update to
// a non-word-aligned target raises Misalign and parks the FSM in IDLE until
// Reset or a Flush to an aligned target. When undefined, targets are silently
// word-aligned.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned INSTR_W  = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [31:0]        Branch_target,
    input  logic               PC_sel,
    input  logic               Flush,
    output logic               Mem_req,
    output logic [31:0]        Mem_addr,
    input  logic               Mem_ready,
    input  logic [INSTR_W-1:0] Mem_rdata,
    output logic [INSTR_W-1:0] Instr,
    output logic               Instr_valid,
    input  logic               Instr_ready,
    output logic [31:0]        PC,
    output logic [31:0]        PC_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic               Misalign
`endif
);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] instr_d;

    logic               accept;
    logic               take_target;
    logic               pc_load;
    logic               trap_hit;
    logic               hold_idle;
    logic [31:0]        pc_target;

    // Decode consumes the held instruction only while it is presented.
    assign accept      = (state_q == ST_VALID) && Instr_ready;
    // Flush always redirects; otherwise PC_sel matters only on an accept,
    // because the PC register is loaded only on accept or flush.
    assign take_target = Flush || PC_sel;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    assign trap_hit  = (Flush || (accept && PC_sel)) && (Branch_target[1:0] != 2'b00);
    assign pc_target = Branch_target;
    assign hold_idle = misalign_q;
    assign Misalign  = misalign_q;

    // Sticky trap flag: set by a misaligned redirect, cleared by Reset or an aligned Flush.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            misalign_q <= 1'b0;
        end else if (trap_hit) begin
            misalign_q <= 1'b1;
        end else if (Flush) begin
            misalign_q <= 1'b0;
        end
    end
`else
    assign trap_hit  = 1'b0;
    assign pc_target = word_align(Branch_target);
    assign hold_idle = 1'b0;
`endif

    // A trapped redirect must leave the PC where it was.
    assign pc_load = (Flush || accept) && !trap_hit;

    // Next-state and instruction-capture logic; Flush outranks accept and Mem_ready.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        if (Flush || accept) begin
            state_d = trap_hit ? ST_IDLE : ST_FETCH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!hold_idle) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (Mem_ready) begin
                        state_d = ST_VALID;
                        instr_d = Mem_rdata;
                    end
                end
                ST_VALID: begin
                    state_d = ST_VALID;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM and instruction registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    assign Mem_req     = (state_q == ST_FETCH);
    assign Mem_addr    = PC;
    assign Instr       = instr_q;
    assign Instr_valid = (state_q == ST_VALID);

    pc_next_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_next_reg (
        .clk_i        (Clk),
        .reset_i      (Reset),
        .load_i       (pc_load),
        .take_target_i(take_target),
        .target_i     (pc_target),
        .pc_o         (PC),
        .pc_plus4_o   (PC_plus4)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit. Instructions returned by memory are
// queued as they are handed to the DUT and compared when decode accepts them.
// Misalign checks run only when FETCH_MISALIGN_TRAP_EN is defined.
module tb_fetch_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Branch_target;
    logic        PC_sel;
    logic        Flush;
    logic        Mem_req;
    logic [31:0] Mem_addr;
    logic        Mem_ready;
    logic [31:0] Mem_rdata;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic        Instr_ready;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        Misalign;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 Clk = ~Clk;

    fetch_pc_unit #(
        .RESET_PC(32'h0000_0000),
        .INSTR_W (32)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Branch_target(Branch_target),
        .PC_sel       (PC_sel),
        .Flush        (Flush),
        .Mem_req      (Mem_req),
        .Mem_addr     (Mem_addr),
        .Mem_ready    (Mem_ready),
        .Mem_rdata    (Mem_rdata),
        .Instr        (Instr),
        .Instr_valid  (Instr_valid),
        .Instr_ready  (Instr_ready),
        .PC           (PC),
        .PC_plus4     (PC_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .Misalign     (Misalign)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard bookkeeping for the coming edge, then advance to 1 ns past it.
    task automatic tick();
        if (Instr_valid === 1'b1) begin
            if (Reset || Flush) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (Instr_ready) begin
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL sb_underflow: observed=accept expected=queued_instr");
                end
                if (exp_q.size() > 0) check("instr_sb", Instr, exp_q.pop_front());
            end
        end
        if (Mem_req === 1'b1 && Mem_ready && !Flush && !Reset) begin
            exp_q.push_back(Mem_rdata);
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Branch_target = '0; PC_sel = 1'b0; Flush = 1'b0;
        Mem_ready = 1'b0; Mem_rdata = '0; Instr_ready = 1'b0;
        tick();
        tick();
        check("rst_mem_req", Mem_req, 0);
        check("rst_valid", Instr_valid, 0);
        check("rst_pc", PC, 32'h0);
        check("rst_pc_plus4", PC_plus4, 32'h4);
        check("rst_instr", Instr, 32'h0);

        // First cycle after reset is IDLE, request appears in the second.
        Reset = 1'b0;
        check("idle_no_req", Mem_req, 0);
        tick();

        // Memory and decode always ready: one instruction every two cycles.
        Mem_ready = 1'b1; Instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("seq_req", Mem_req, 1);
            check("seq_addr", Mem_addr, 32'(4 * i));
            check("seq_valid_lo", Instr_valid, 0);
            Mem_rdata = 32'hA000_0000 + 32'(i);
            tick();
            check("seq_valid_hi", Instr_valid, 1);
            check("seq_req_lo", Mem_req, 0);
            tick();
        end

        // Memory stalls for 5 cycles at 0x10; address must stay put.
        Mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_req", Mem_req, 1);
            check("stall_addr", Mem_addr, 32'h10);
            Mem_rdata = 32'hEEEE_0000 + 32'(k);
            tick();
        end
        Mem_ready = 1'b1; Mem_rdata = 32'h1234_5678; Instr_ready = 1'b0;
        tick();
        check("stall_cap_valid", Instr_valid, 1);
        check("stall_cap_instr", Instr, 32'h1234_5678);

        // Decode back-pressure: held instruction and PC must not move.
        for (int k = 0; k < 3; k++) begin
            Mem_rdata = 32'h5555_0000 + 32'(k);
            Mem_ready = (k % 2 == 1);
            tick();
            check("hold_instr", Instr, 32'h1234_5678);
            check("hold_pc", PC, 32'h10);
            check("hold_valid", Instr_valid, 1);
        end

        // Flush while holding an instruction: drop it and refetch at 0x8.
        Flush = 1'b1; Branch_target = 32'h8;
        tick();
        Flush = 1'b0;
        check("flush_valid_lo", Instr_valid, 0);
        check("flush_req", Mem_req, 1);
        check("flush_addr", Mem_addr, 32'h8);

        Mem_ready = 1'b1; Mem_rdata = 32'hCAFE_0008;
        tick();
        check("br_valid", Instr_valid, 1);

        // Accept with PC_sel=1 redirects to Branch_target.
        Mem_ready = 1'b0; Instr_ready = 1'b1; PC_sel = 1'b1; Branch_target = 32'h40;
        tick();
        check("br_addr", Mem_addr, 32'h40);
        check("br_req", Mem_req, 1);
        check("br_valid_lo", Instr_valid, 0);

        // PC_sel outside an accept has no effect.
        Branch_target = 32'h100;
        tick();
        check("pcsel_ignored", Mem_addr, 32'h40);
        PC_sel = 1'b0;

        // Flush in FETCH beats a simultaneous Mem_ready.
        Flush = 1'b1; Branch_target = 32'h60; Mem_ready = 1'b1; Mem_rdata = 32'hDEAD_BEEF;
        tick();
        Flush = 1'b0;
        check("flushf_pc", PC, 32'h60);
        check("flushf_valid", Instr_valid, 0);
        check("flushf_instr", Instr, 32'hCAFE_0008);
        check("flushf_req", Mem_req, 1);

        Mem_rdata = 32'hBEEF_0060;
        tick();
        check("fa_valid", Instr_valid, 1);

        // Flush and accept together: flush wins, PC goes to the target not PC+4.
        Mem_ready = 1'b0; Instr_ready = 1'b1; Flush = 1'b1; Branch_target = 32'h80;
        tick();
        Flush = 1'b0;
        check("fa_pc", PC, 32'h80);
        check("fa_valid_lo", Instr_valid, 0);
        check("fa_req", Mem_req, 1);

`ifndef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect is forced onto a word boundary.
        Flush = 1'b1; Branch_target = 32'h86;
        tick();
        Flush = 1'b0;
        check("align_pc", PC, 32'h84);
`endif

        // Reset during FETCH with Mem_ready high: nothing captured.
        Reset = 1'b1; Mem_ready = 1'b1; Mem_rdata = 32'h7777_7777;
        tick();
        Reset = 1'b0;
        check("rstf_req", Mem_req, 0);
        check("rstf_valid", Instr_valid, 0);
        check("rstf_pc", PC, 32'h0);
        check("rstf_instr", Instr, 32'h0);
        tick();
        check("rstf_idle_valid", Instr_valid, 0);
        check("rstf_req_again", Mem_req, 1);
        check("rstf_addr", Mem_addr, 32'h0);
        Mem_ready = 1'b0;

        // PC wraps from 0xFFFF_FFFC to 0 on a sequential accept.
        Flush = 1'b1; Branch_target = 32'hFFFF_FFFC;
        tick();
        Flush = 1'b0;
        check("wrap_pc_top", PC, 32'hFFFF_FFFC);
        check("wrap_plus4_top", PC_plus4, 32'h0);
        Mem_ready = 1'b1; Mem_rdata = 32'h0000_00FC;
        tick();
        Mem_ready = 1'b0; Instr_ready = 1'b1; PC_sel = 1'b0;
        tick();
        check("wrap_pc", PC, 32'h0);
        check("wrap_plus4", PC_plus4, 32'h4);
        check("wrap_addr", Mem_addr, 32'h0);
        check("wrap_req", Mem_req, 1);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned branch on accept traps: PC held, FSM parked in IDLE.
        Mem_ready = 1'b1; Mem_rdata = 32'h0000_0011;
        tick();
        Mem_ready = 1'b0; PC_sel = 1'b1; Branch_target = 32'h42; Instr_ready = 1'b1;
        tick();
        PC_sel = 1'b0;
        check("mis_flag", Misalign, 1);
        check("mis_pc", PC, 32'h0);
        check("mis_req", Mem_req, 0);
        check("mis_valid", Instr_valid, 0);
        tick();
        check("mis_park_req", Mem_req, 0);
        check("mis_park_pc", PC, 32'h0);
        Flush = 1'b1; Branch_target = 32'h40;
        tick();
        Flush = 1'b0;
        check("mis_clear", Misalign, 0);
        check("mis_resume_req", Mem_req, 1);
        check("mis_resume_pc", PC, 32'h40);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
